avalon_read_scheduler: RTL

Shares one Avalon burst read master between `NUM_REQ` requesters. Each requester posts a read job (base, length, fixed-location flag). The scheduler picks a job by round-robin and splits it into chunks of at most `CHUNK_BYTES`. It sequences the read master's control port (`control_go` / `control_done`) chunk by chunk and pulses a per-requester completion when the job ends. It sits between client DMA engines and the read master's control inputs. It also publishes the current owner ID so the user-data path can be routed.

---
 rtl/avalon_read_scheduler.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/avalon_read_scheduler.sv
// Round-robin scheduler sharing one Avalon burst read master between NUM_REQ
// requesters; each job is split into chunks of at most CHUNK_BYTES.
module avalon_read_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int ADDRESSWIDTH = 32,
    parameter int CHUNK_BYTES  = 64,
    parameter int IDW          = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ADDRESSWIDTH-1:0] req_base,
    input  logic [NUM_REQ*ADDRESSWIDTH-1:0] req_length,
    input  logic [NUM_REQ-1:0]              req_fixed,
    output logic [NUM_REQ-1:0]              job_done,
    output logic                            control_go,
    output logic [ADDRESSWIDTH-1:0]         control_read_base,
    output logic [ADDRESSWIDTH-1:0]         control_read_length,
    output logic                            control_fixed_location,
    input  logic                            control_done,
    output logic [IDW-1:0]                  owner_id,
    output logic                            owner_valid,
    output logic                            busy
);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_LOW, S_WAIT_HIGH, S_DONE} state_t;

    localparam logic [ADDRESSWIDTH-1:0] CHUNK_L = ADDRESSWIDTH'(CHUNK_BYTES);

    function automatic logic [ADDRESSWIDTH-1:0] chunk_len(input logic [ADDRESSWIDTH-1:0] rem);
        return (rem > CHUNK_L) ? CHUNK_L : rem;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t                  state_q;
    logic [IDW-1:0]          rr_q;
    logic [ADDRESSWIDTH-1:0] base_q;
    logic [ADDRESSWIDTH-1:0] rem_q;
    logic                    fixed_q;
    logic [IDW-1:0]          owner_q;
    logic                    go_q;
    logic [ADDRESSWIDTH-1:0] rd_base_q;
    logic [ADDRESSWIDTH-1:0] rd_len_q;
    logic                    rd_fixed_q;
    logic [NUM_REQ-1:0]      job_done_q;
    logic                    owner_valid_q;
    logic                    busy_q;

    logic                    found_s;
    logic [IDW-1:0]          win_s;
    logic [NUM_REQ-1:0]      grant_s;
    logic [ADDRESSWIDTH-1:0] sel_base_s;
    logic [ADDRESSWIDTH-1:0] sel_len_s;
    logic                    sel_fixed_s;
    logic [ADDRESSWIDTH-1:0] rem_d;
    logic [ADDRESSWIDTH-1:0] base_d;

    // Round-robin pick: scan from rr_q upward and take the first valid requester.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        grant_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = (int'(rr_q) + i) % NUM_REQ;
            if (!found_s && req_valid[idx[IDW-1:0]]) begin
                found_s                = 1'b1;
                win_s                  = idx[IDW-1:0];
                grant_s[idx[IDW-1:0]]  = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Descriptor of the winner and the post-chunk remaining/base values.
    always_comb begin
        sel_base_s  = req_base[int'(win_s)*ADDRESSWIDTH +: ADDRESSWIDTH];
        sel_len_s   = req_length[int'(win_s)*ADDRESSWIDTH +: ADDRESSWIDTH];
        sel_fixed_s = req_fixed[win_s];
        rem_d       = rem_q - rd_len_q;
        if (fixed_q) begin
            base_d = base_q;
        end else begin
            base_d = base_q + rd_len_q;
        end
    end

    // Accept is only offered in IDLE and is forced low while reset is held.
    assign req_ready = (reset && (state_q == S_IDLE)) ? grant_s : '0;

    // Scheduler FSM with all control-port outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            rr_q          <= '0;
            base_q        <= '0;
            rem_q         <= '0;
            fixed_q       <= 1'b0;
            owner_q       <= '0;
            go_q          <= 1'b0;
            rd_base_q     <= '0;
            rd_len_q      <= '0;
            rd_fixed_q    <= 1'b0;
            job_done_q    <= '0;
            owner_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            go_q       <= 1'b0;
            job_done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (found_s) begin
                        base_q        <= sel_base_s;
                        rem_q         <= sel_len_s;
                        fixed_q       <= sel_fixed_s;
                        owner_q       <= win_s;
                        rr_q          <= (win_s == IDW'(NUM_REQ-1)) ? '0 : win_s + 1'b1;
                        owner_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                        if (sel_len_s == '0) begin
                            state_q    <= S_DONE;
                            job_done_q <= onehot(win_s);
                        end else begin
                            state_q    <= S_LAUNCH;
                            go_q       <= 1'b1;
                            rd_base_q  <= sel_base_s;
                            rd_len_q   <= chunk_len(sel_len_s);
                            rd_fixed_q <= sel_fixed_s;
                        end
                    end
                end
                S_LAUNCH: begin
                    state_q <= S_WAIT_LOW;
                end
                // A done level left over from before the go must be seen low first.
                S_WAIT_LOW: begin
                    if (!control_done) begin
                        state_q <= S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (control_done) begin
                        rem_q  <= rem_d;
                        base_q <= base_d;
                        if (rem_d != '0) begin
                            state_q   <= S_LAUNCH;
                            go_q      <= 1'b1;
                            rd_base_q <= base_d;
                            rd_len_q  <= chunk_len(rem_d);
                        end else begin
                            state_q    <= S_DONE;
                            job_done_q <= onehot(owner_q);
                        end
                    end
                end
                S_DONE: begin
                    state_q       <= S_IDLE;
                    owner_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
                default: begin
                    state_q       <= S_IDLE;
                    owner_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign job_done               = job_done_q;
    assign control_go             = go_q;
    assign control_read_base      = rd_base_q;
    assign control_read_length    = rd_len_q;
    assign control_fixed_location = rd_fixed_q;
    assign owner_id               = owner_q;
    assign owner_valid            = owner_valid_q;
    assign busy                   = busy_q;

endmodule
